// File: rtl/regfile_arb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared constants and types for the register-file read-port arbiter.
//   The arbiter top module and the round-robin picker both import it.
//
//   Contents:
//     NUM_REQ     default number of requesters sharing the read port
//     DATA_W      default register data width
//     REG_ADDR_W  register address width (32 architectural registers)
//     ZERO_REG    address of the hard-wired zero register
//     req_id_t    requester index carried with every response
// ----------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [1:0] req_id_t;

endpackage : regfile_arb_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. The search starts at index ptr,
//   walks upward, wraps from N-1 back to 0, and grants the first requester
//   it finds with its request bit set. The grant is one-hot, or all-zero
//   when nobody is requesting.
//
//   Ports:
//     req  [N-1:0]     request vector
//     ptr  [ID_W-1:0]  index where the search starts (must be < N)
//     gnt  [N-1:0]     one-hot grant
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt
);

    // Highest legal index. The walk wraps here rather than at 2**ID_W,
    // so non-power-of-two requester counts are handled too.
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N - 1);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        // NOTE: every variable gets a value before the loop, so no path leaves
        // one unassigned and no latch is inferred.
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = ptr;
        for (int off = 0; off < N; off++) begin
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
            w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/regfile_read_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_read_arbiter
//   Shares one register-file read port among NUM_REQ requesters.
//   Each cycle a round-robin pick selects at most one requester. The picked
//   address goes out on rf_addr. The read data comes back on rf_data in the
//   same cycle and is registered as the response. The response appears
//   exactly one cycle after the grant and is tagged with the requester index.
//
//   Read-data resolution, from highest to lowest priority:
//     address ZERO_REG         -> zero
//     same-cycle write to addr -> wr_data (write bypass)
//     otherwise                -> rf_data
//
//   Ports:
//     clk         rising-edge clock
//     reset       synchronous active-high reset
//     req         per-requester request, held until granted
//     req_addr    packed addresses, slice i belongs to requester i
//     stall       suppresses new grants
//     gnt         one-hot grant (combinational)
//     rf_addr     register-file read address (0 when idle)
//     rf_data     register-file read data for rf_addr
//     wr_en       register-file write strobe this cycle
//     wr_addr     register-file write address
//     wr_data     register-file write data
//     resp_valid  response valid, one cycle per grant
//     resp_id     requester owning the response
//     resp_data   registered read data
// ----------------------------------------------------------------------------
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ,
    parameter int DATA_W  = regfile_arb_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic                          stall,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [REG_ADDR_W-1:0]         rf_addr,
    input  logic [DATA_W-1:0]             rf_data,
    input  logic                          wr_en,
    input  logic [REG_ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          resp_valid,
    output req_id_t                       resp_id,
    output logic [DATA_W-1:0]             resp_data
);

    localparam int      ID_W     = $bits(req_id_t);
    localparam req_id_t LAST_IDX = req_id_t'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_id_t           r_ptr;
    logic              r_resp_valid;
    req_id_t           r_resp_id;
    logic [DATA_W-1:0] r_resp_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_any_gnt;
    req_id_t               w_gnt_id;
    logic [REG_ADDR_W-1:0] w_gnt_addr;
    req_id_t               w_ptr_next;
    logic [DATA_W-1:0]     w_read_data;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick_gnt)
    );

    // Reset and stall both veto the pick. The pointer only advances on a
    // real grant, so a stalled cycle leaves the rotation where it was.
    assign w_gnt     = (reset || stall) ? '0 : w_pick_gnt;
    assign w_any_gnt = |w_gnt;

    // One-hot grant -> index and selected address. Both stay zero when
    // there is no grant, so rf_addr is 0 when the port is idle.
    always_comb begin
        w_gnt_id   = '0;
        w_gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_id   = req_id_t'(i);
                w_gnt_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

    assign w_ptr_next = (w_gnt_id == LAST_IDX) ? '0 : w_gnt_id + 1'b1;

    // Read-data resolution. The zero register wins over the bypass, so a
    // write aimed at ZERO_REG can never leak into a response.
    always_comb begin
        if (w_gnt_addr == ZERO_REG) begin
            w_read_data = '0;
        end else if (wr_en && (wr_addr == w_gnt_addr)) begin
            w_read_data = wr_data;
        end else begin
            w_read_data = rf_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointer and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_ptr       <= w_ptr_next;
                r_resp_id   <= w_gnt_id;
                r_resp_data <= w_read_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt     = w_gnt;
    assign rf_addr = w_gnt_addr;

    // A reset arriving while a response is on its way kills that response
    // in the cycle reset is seen. The register is cleared at the same edge,
    // so nothing stale follows.
    assign resp_valid = r_resp_valid && !reset;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;

endmodule : regfile_read_arbiter

// File: tb/tb_regfile_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_read_arbiter
//   Scenario tasks drive requests and check grants and rf_addr inline.
//   For each grant they expect, they push the expected response onto a
//   scoreboard queue. A negedge monitor pops and compares the responses
//   when they fall due. The register file is modelled by a bench-side
//   array that answers rf_addr.
// ----------------------------------------------------------------------------
module tb_regfile_read_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*5-1:0] req_addr;
    logic            stall;
    logic [NR-1:0]   gnt;
    logic [4:0]      rf_addr;
    logic [DW-1:0]   rf_data;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [DW-1:0]   wr_data;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_data;

    logic [DW-1:0] mem [32];
    assign rf_data = mem[rf_addr];

    always #5 clk = ~clk;

    regfile_read_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .stall      (stall),
        .gnt        (gnt),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;

    always @(posedge clk) cyc++;

    // Expected read data for address a under the current write-port inputs.
    function automatic logic [DW-1:0] model_data(input logic [4:0] a);
        if (a == 5'd31) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    task automatic push_exp(input int id, input logic [4:0] a);
        exp_t e;
        e.id   = id;
        e.data = model_data(a);
        e.due  = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Response monitor: resp_valid must be high exactly when a scoreboard
    // entry falls due, unless reset is killing it in that same cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   exp_v;
            exp_v = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                if (e.due == cyc && !reset) exp_v = 1'b1;
            end
            vectors++;
            if (resp_valid !== exp_v) begin
                miscompares++;
                $display("FAIL resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (resp_id !== 2'(e.id) || resp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL resp cyc=%0d got id=%0d data=%h want id=%0d data=%h",
                             cyc, resp_id, resp_data, e.id, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_gnt got=%b want=0000", gnt);
        end
        vectors++;
        if (rf_addr !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_rf_addr got=%0d want=0", rf_addr);
        end
        vectors++;
        if (resp_id !== 2'd0 || resp_data !== '0) begin
            miscompares++;
            $display("FAIL reset_resp got id=%0d data=%h want 0/0", resp_id, resp_data);
        end
        reset = 1'b0;
        req   = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_k [5] = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int i = 0; i < NR; i++) set_addr(i, 5'(3 + 4*i));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 4'(1 << exp_k[i])) begin
                miscompares++;
                $display("FAIL rr_gnt step=%0d got=%b want=%b", i, gnt, 4'(1 << exp_k[i]));
            end
            vectors++;
            if (rf_addr !== 5'(3 + 4*exp_k[i])) begin
                miscompares++;
                $display("FAIL rr_addr step=%0d got=%0d want=%0d", i, rf_addr, 3 + 4*exp_k[i]);
            end
            push_exp(exp_k[i], 5'(3 + 4*exp_k[i]));
            tick();
        end
        req = '0;
    endtask

    // Entry state: ptr=1. Exit state: ptr=3.
    task automatic test_zero_reg();
        req = 4'b0100;
        set_addr(2, 5'd31);
        for (int i = 0; i < 2; i++) begin
            wr_en   = (i == 1);
            wr_addr = 5'd31;
            wr_data = 64'h5555_AAAA_5555_AAAA;
            @(negedge clk);
            vectors++;
            if (gnt !== 4'b0100 || rf_addr !== 5'd31) begin
                miscompares++;
                $display("FAIL zero_gnt step=%0d got gnt=%b addr=%0d want 0100/31", i, gnt, rf_addr);
            end
            push_exp(2, 5'd31);
            tick();
        end
        wr_en = 1'b0;
        req   = '0;
    endtask

    // Entry state: ptr=3, so requester 0 wins first once stall drops.
    task automatic test_stall();
        int exp_k [2] = '{0, 2};
        req = 4'b0101;
        set_addr(0, 5'd9);
        set_addr(2, 5'd12);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 4'b0000 || rf_addr !== 5'd0) begin
                miscompares++;
                $display("FAIL stall_gnt step=%0d got gnt=%b addr=%0d want 0000/0", i, gnt, rf_addr);
            end
            tick();
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 4'(1 << exp_k[i])) begin
                miscompares++;
                $display("FAIL unstall_gnt step=%0d got=%b want=%b", i, gnt, 4'(1 << exp_k[i]));
            end
            push_exp(exp_k[i], (exp_k[i] == 0) ? 5'd9 : 5'd12);
            tick();
        end
        req = '0;
    endtask

    // Entry state: ptr=3. Exit state: ptr=2.
    task automatic test_bypass();
        logic [4:0] wa [2] = '{5'd5, 5'd6};
        req = 4'b0010;
        set_addr(1, 5'd5);
        wr_en   = 1'b1;
        wr_data = 64'h1234;
        for (int i = 0; i < 2; i++) begin
            wr_addr = wa[i];
            @(negedge clk);
            vectors++;
            if (gnt !== 4'b0010 || rf_addr !== 5'd5) begin
                miscompares++;
                $display("FAIL bypass_gnt step=%0d got gnt=%b addr=%0d want 0010/5", i, gnt, rf_addr);
            end
            push_exp(1, 5'd5);
            tick();
        end
        wr_en = 1'b0;
        req   = '0;
    endtask

    // Entry state: ptr=2. Exit state: ptr=2.
    task automatic test_reset_mid();
        req = 4'b1000;
        set_addr(3, 5'd20);
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL pre_reset_gnt got=%b want=1000", gnt);
        end
        push_exp(3, 5'd20);
        tick();
        reset = 1'b1;
        req   = 4'b0110;
        set_addr(1, 5'd17);
        set_addr(2, 5'd18);
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0000 || rf_addr !== 5'd0 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got gnt=%b addr=%0d valid=%b want 0000/0/0",
                     gnt, rf_addr, resp_valid);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0010 || rf_addr !== 5'd17) begin
            miscompares++;
            $display("FAIL post_reset_gnt got gnt=%b addr=%0d want 0010/17", gnt, rf_addr);
        end
        push_exp(1, 5'd17);
        tick();
        req = '0;
    endtask

    // Drive ptr to 3, wrap to requester 0, then confirm ptr became 1.
    task automatic test_wrap();
        logic [3:0] reqs  [3] = '{4'b0100, 4'b0001, 4'b0011};
        logic [3:0] gnts  [3] = '{4'b0100, 4'b0001, 4'b0010};
        int         ids   [3] = '{2, 0, 1};
        logic [4:0] addrs [3] = '{5'd18, 5'd1, 5'd2};
        set_addr(0, 5'd1);
        set_addr(1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            req = reqs[i];
            @(negedge clk);
            vectors++;
            if (gnt !== gnts[i]) begin
                miscompares++;
                $display("FAIL wrap_gnt step=%0d got=%b want=%b", i, gnt, gnts[i]);
            end
            push_exp(ids[i], addrs[i]);
            tick();
        end
        req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'hF00D_0000_0000_0000 | 64'(i*17 + 1);
        mem[31]  = 64'hDEAD;
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        stall    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        tick();
        tick();
        mon_en = 1'b1;

        test_reset();
        test_round_robin();
        test_zero_reg();
        test_stall();
        test_bypass();
        test_reset_mid();
        test_wrap();

        repeat (3) tick();
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile_read_arbiter
